// File: rtl/clk_div_ctrl_if.sv
// Configuration channel of the runtime clock divider: valid/ready word
// offer plus the controller's error and applied status pulses.
interface clk_div_ctrl_if #(
    parameter int unsigned DIV_W = 32
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    logic             applied;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err,
        input  applied
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready,
        output cfg_err,
        output applied
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free runtime-programmable divider for the 12 MHz fabric clock: the half-period
// changes only on a full-period boundary and stops are honoured only while o_out_clk is low.
module clk_div_ctrl #(
    parameter int unsigned DIV_W = 32
) (
    input  logic          i_in_clk,
    input  logic          i_rst,
    input  logic          i_en,
    clk_div_ctrl_if.slave cfg,
    output logic          o_out_clk,
    output logic          o_tick,
    output logic          o_running
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PEND
    } state_t;

    state_t           r_state, w_state_n;
    logic [DIV_W-1:0] r_active, w_active_n;
    logic [DIV_W-1:0] r_pending, w_pending_n;
    logic [DIV_W-1:0] r_cnt, w_cnt_n;
    logic             r_out_clk, w_out_clk_n;
    logic             r_tick, w_tick_n;
    logic             r_applied, w_applied_n;
    logic             r_cfg_err;
    logic             r_running;

    logic w_cfg_ready;
    logic w_hs;
    logic w_hs_ok;
    logic w_term;
    logic w_fall;

    // Ready depends on state only, so no input-to-output combinational path exists.
    assign w_cfg_ready = (r_state != S_PEND);
    assign w_hs        = cfg.cfg_valid && w_cfg_ready;
    assign w_hs_ok     = w_hs && (cfg.cfg_half != '0);
    assign w_term      = (r_cnt == r_active - DIV_W'(1));
    assign w_fall      = w_term && r_out_clk;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_state_n   = r_state;
        w_active_n  = r_active;
        w_pending_n = r_pending;
        w_cnt_n     = r_cnt;
        w_out_clk_n = r_out_clk;
        w_tick_n    = 1'b0;
        w_applied_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_out_clk_n = 1'b0;
                w_cnt_n     = '0;
                if (w_hs_ok) begin
                    w_active_n  = cfg.cfg_half;
                    w_applied_n = 1'b1;
                end
                if (i_en && (w_active_n != '0)) begin
                    w_state_n = S_RUN;
                end
            end

            S_RUN, S_PEND: begin
                if (!i_en && !r_out_clk) begin
                    // Stop while low: leave immediately, committing any waiting word.
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                    if (r_state == S_PEND) begin
                        w_active_n  = r_pending;
                        w_applied_n = 1'b1;
                    end else if (w_hs_ok) begin
                        w_active_n  = cfg.cfg_half;
                        w_applied_n = 1'b1;
                    end
                end else begin
                    w_cnt_n = w_term ? '0 : r_cnt + DIV_W'(1);
                    if (w_term) begin
                        w_out_clk_n = !r_out_clk;
                        w_tick_n    = 1'b1;
                    end
                    if (w_fall && (r_state == S_PEND)) begin
                        w_active_n  = r_pending;
                        w_applied_n = 1'b1;
                        w_state_n   = S_RUN;
                    end
                    if (w_hs_ok) begin
                        if (w_fall && !i_en) begin
                            w_active_n  = cfg.cfg_half;
                            w_applied_n = 1'b1;
                        end else begin
                            w_pending_n = cfg.cfg_half;
                            w_state_n   = S_PEND;
                        end
                    end
                    // A stop requested while high completes on the falling edge.
                    if (w_fall && !i_en) begin
                        w_state_n = S_IDLE;
                    end
                end
            end

            default: w_state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_in_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_active  <= '0;
            r_pending <= '0;
            r_cnt     <= '0;
            r_out_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_applied <= 1'b0;
            r_cfg_err <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_active  <= w_active_n;
            r_pending <= w_pending_n;
            r_cnt     <= w_cnt_n;
            r_out_clk <= w_out_clk_n;
            r_tick    <= w_tick_n;
            r_applied <= w_applied_n;
            r_cfg_err <= w_hs && (cfg.cfg_half == '0);
            r_running <= (r_state != S_IDLE);
        end
    end

    assign cfg.cfg_ready = w_cfg_ready;
    assign cfg.cfg_err   = r_cfg_err;
    assign cfg.applied   = r_applied;
    assign o_out_clk     = r_out_clk;
    assign o_tick        = r_tick;
    assign o_running     = r_running;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: a directed vector table, hand-written
// corner sequences and a randomized run, all compared against a phase-level model.
module tb_clk_div_ctrl;

    localparam int unsigned DIV_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic out_clk, tick, running;

    clk_div_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

    clk_div_ctrl #(.DIV_W(DIV_W)) dut (
        .i_in_clk (clk),
        .i_rst    (rst),
        .i_en     (en),
        .cfg      (cfg_if),
        .o_out_clk(out_clk),
        .o_tick   (tick),
        .o_running(running)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: tracks cycles left in the current half-phase rather than a counter.
    bit          m_on, m_held, m_clk, m_tick, m_err, m_app, m_run;
    int unsigned m_act, m_pend, m_left;

    typedef struct {
        bit          rst;
        bit          en;
        bit          valid;
        int unsigned half;
        logic [5:0]  exp;   // {out_clk, tick, cfg_err, applied, running, cfg_ready}
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {out_clk, tick, cfg_if.cfg_err, cfg_if.applied, running, cfg_if.cfg_ready};
    endfunction

    function automatic logic [5:0] model_out();
        return {m_clk, m_tick, m_err, m_app, m_run, !m_held};
    endfunction

    task automatic model_step(input bit r, input bit e, input bit v, input int unsigned h);
        bit good;
        bit held0;
        if (r) begin
            m_on = 0; m_held = 0; m_act = 0; m_pend = 0; m_left = 0;
            m_clk = 0; m_tick = 0; m_err = 0; m_app = 0; m_run = 0;
            return;
        end
        good   = v && !m_held && (h != 0);
        m_err  = v && !m_held && (h == 0);
        m_tick = 0;
        m_app  = 0;
        m_run  = m_on;
        held0  = m_held;
        if (!m_on) begin
            m_clk = 0;
            if (good) begin m_act = h; m_app = 1; end
            if (e && m_act != 0) begin m_on = 1; m_left = m_act; end
        end else if (!e && !m_clk) begin
            m_on = 0;
            if (held0) begin m_act = m_pend; m_held = 0; m_app = 1; end
            else if (good) begin m_act = h; m_app = 1; end
        end else begin
            if (m_left == 1) begin
                m_clk  = !m_clk;
                m_tick = 1;
                if (!m_clk) begin
                    if (held0) begin m_act = m_pend; m_held = 0; m_app = 1; end
                    if (!e) begin
                        m_on = 0;
                        if (good) begin m_act = h; m_app = 1; good = 0; end
                    end
                end
                m_left = m_act;
            end else begin
                m_left--;
            end
            if (good) begin m_pend = h; m_held = 1; end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int unsigned h);
        rst              = r;
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_half  = h;
        model_step(r, e, v, h);
        @(posedge clk);
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    // Step with fixed en until out_clk toggles to 'want'; returns cycles taken, bounded.
    task automatic wait_edge(input bit want, input bit e, output int cyc);
        cyc = 0;
        do begin
            step(0, e, 0, 0);
            cyc++;
        end while (!(out_clk == want && tick) && cyc < 64);
        check("edge_seen", 32'({out_clk, tick}), 32'({want, 1'b1}));
    endtask

    task automatic go_idle();
        int k;
        k = 0;
        do begin
            step(0, 0, 0, 0);
            k++;
        end while (running && k < 64);
        check("go_idle", 32'(running), 32'd0);
    endtask

    initial begin
        int  cyc, cyc2;
        bit  prev;
        bit  r_en;

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_half  = '0;

        // N=3 start, zero word in RUN, stop while low, zero word in IDLE.
        tbl[0]  = '{1, 0, 0, 0, 6'b000001};
        tbl[1]  = '{0, 1, 1, 3, 6'b000101};
        tbl[2]  = '{0, 1, 0, 0, 6'b000011};
        tbl[3]  = '{0, 1, 0, 0, 6'b000011};
        tbl[4]  = '{0, 1, 0, 0, 6'b110011};
        tbl[5]  = '{0, 1, 0, 0, 6'b100011};
        tbl[6]  = '{0, 1, 0, 0, 6'b100011};
        tbl[7]  = '{0, 1, 0, 0, 6'b010011};
        tbl[8]  = '{0, 1, 0, 0, 6'b000011};
        tbl[9]  = '{0, 1, 0, 0, 6'b000011};
        tbl[10] = '{0, 1, 0, 0, 6'b110011};
        tbl[11] = '{0, 1, 1, 0, 6'b101011};
        tbl[12] = '{0, 1, 0, 0, 6'b100011};
        tbl[13] = '{0, 1, 0, 0, 6'b010011};
        tbl[14] = '{0, 0, 0, 0, 6'b000011};
        tbl[15] = '{0, 0, 0, 0, 6'b000001};
        tbl[16] = '{0, 0, 1, 0, 6'b001001};
        tbl[17] = '{0, 0, 0, 0, 6'b000001};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].half);
            check($sformatf("table[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Stop while high at N=4: the high phase still lasts 4 cycles.
        step(0, 0, 1, 4);
        wait_edge(1, 1, cyc);
        wait_edge(0, 0, cyc);
        check("stop_high_len", 32'(cyc), 32'd4);
        step(0, 0, 0, 0);
        check("stop_high_idle", 32'(running), 32'd0);

        // Stop while low: IDLE next cycle, no tick.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("stop_low_out", 32'({out_clk, tick}), 32'd0);
        step(0, 0, 0, 0);
        check("stop_low_idle", 32'(running), 32'd0);

        // Reconfigure N=3 -> 5 mid high phase.
        step(0, 0, 1, 3);
        wait_edge(1, 1, cyc);
        step(0, 1, 1, 5);
        check("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        wait_edge(0, 1, cyc);
        check("old_high_rest", 32'(cyc), 32'd2);
        check("boundary_applied", 32'(cfg_if.applied), 32'd1);
        check("boundary_ready", 32'(cfg_if.cfg_ready), 32'd1);
        wait_edge(1, 1, cyc);
        check("new_low_len", 32'(cyc), 32'd5);
        wait_edge(0, 1, cyc);
        check("new_high_len", 32'(cyc), 32'd5);
        go_idle();

        // N=1: toggle every cycle, tick stuck high; then reset while high.
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            prev = out_clk;
            step(0, 1, 0, 0);
            check("n1_tick", 32'(tick), 32'd1);
            check("n1_toggle", 32'(out_clk), 32'(!prev));
        end
        if (!out_clk) step(0, 1, 0, 0);
        check("n1_high_before_rst", 32'(out_clk), 32'd1);
        step(1, 1, 0, 0);
        check("rst_outputs", 32'(dut_out()), 32'b000001);

        // Stop during PEND with out_clk high (N=2 -> 7), then period 14.
        step(0, 0, 1, 2);
        wait_edge(1, 1, cyc);
        step(0, 1, 1, 7);
        check("pend2_ready", 32'(cfg_if.cfg_ready), 32'd0);
        step(0, 0, 0, 0);
        check("pend_stop_edge", 32'(dut_out()), 32'b010111);
        step(0, 0, 0, 0);
        check("pend_stop_idle", 32'(running), 32'd0);
        wait_edge(1, 1, cyc);
        wait_edge(0, 1, cyc);
        wait_edge(1, 1, cyc2);
        check("period_14", 32'(cyc + cyc2), 32'd14);

        // Randomized traffic against the model.
        r_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) r_en = !r_en;
            step(($urandom_range(299) == 0), r_en, ($urandom_range(7) == 0), $urandom_range(6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
